// File: rtl/mfe_pkg.sv
// mfe_pkg: shared constants, reader state and pixel record for the median-filter result path.
package mfe_pkg;
   localparam int IMG_W  = 128;
   localparam int IMG_H  = 128;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int X_W    = 7;
   localparam int Y_W    = 7;
   typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_DRAIN, RD_DONE} rd_state_t;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic              last;
   } pixel_t;
endpackage

// File: rtl/mfe_result_reader_if.sv
// mfe_result_reader_if: result-RAM read port plus outgoing pixel stream of the reader.
interface mfe_result_reader_if import mfe_pkg::*; ();
   logic [ADDR_W-1:0] raddr;
   logic              ren;
   logic [DATA_W-1:0] rdata;
   logic              pix_valid;
   logic              pix_ready;
   logic [DATA_W-1:0] pix_data;
   logic [X_W-1:0]    pix_x;
   logic [Y_W-1:0]    pix_y;
   logic              pix_last;
   modport master (output raddr, ren, pix_valid, pix_data, pix_x, pix_y, pix_last,
                   input rdata, pix_ready);
   modport slave  (input raddr, ren, pix_valid, pix_data, pix_x, pix_y, pix_last,
                   output rdata, pix_ready);
endinterface

// File: rtl/mfe_rd_fifo2.sv
// mfe_rd_fifo2: 2-entry pixel FIFO; entry 0 is always the head so it can drive outputs directly.
module mfe_rd_fifo2 import mfe_pkg::*; (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_push,
   input  logic       i_pop,
   input  pixel_t     i_din,
   output pixel_t     o_head,
   output logic [1:0] o_occ
);
   pixel_t     r_mem [2];
   logic [1:0] r_occ;
   logic       w_widx;
   // write slot is the occupancy left after this cycle's pop
   assign w_widx = r_occ[0] ^ i_pop;
   assign o_head = r_mem[0];
   assign o_occ  = r_occ;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_occ    <= '0;
      end else begin
         if (i_pop) r_mem[0] <= r_mem[1];
         if (i_push) r_mem[w_widx] <= i_din;
         r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
      end
endmodule

// File: rtl/mfe_result_reader.sv
// mfe_result_reader: raster sweep of the result RAM streamed out as (x,y)-tagged pixels.
// Defining MFE_RD_CHECKSUM_EN adds o_checksum, the mod-2^16 sum of delivered pixels.
module mfe_result_reader import mfe_pkg::*; (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_done,
`ifdef MFE_RD_CHECKSUM_EN
   output logic [15:0] o_checksum,
`endif
   mfe_result_reader_if.master bus
);
   rd_state_t         r_state, w_next;
   logic [ADDR_W-1:0] r_addr, r_inf_addr;
   logic              r_inflight;
   logic              w_ren, w_pop;
   logic [1:0]        w_occ, w_pending;
   pixel_t            w_head, w_din;

   assign w_pop     = bus.pix_valid && bus.pix_ready;
   // slots committed after this edge: buffered + in flight - leaving now
   assign w_pending = w_occ + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_din     = '{data: bus.rdata, x: r_inf_addr[X_W-1:0], y: r_inf_addr[ADDR_W-1:X_W], last: &r_inf_addr};

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= RD_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         RD_IDLE:  w_next = i_start ? RD_FETCH : RD_IDLE;
         RD_FETCH: w_next = (w_ren && &r_addr) ? RD_DRAIN : RD_FETCH;
         RD_DRAIN: w_next = (w_pop && w_head.last) ? RD_DONE : RD_DRAIN;
         RD_DONE:  w_next = RD_IDLE;
         default:  w_next = RD_IDLE;
      endcase
   end

   always_comb begin
      w_ren  = (r_state == RD_FETCH) && !w_pending[1];
      o_busy = (r_state == RD_FETCH) || (r_state == RD_DRAIN);
      o_done = (r_state == RD_DONE);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_addr     <= '0;
         r_inf_addr <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_ren;
         r_inf_addr <= r_addr;
         if (w_ren) r_addr <= r_addr + 1'b1;
      end

   mfe_rd_fifo2 u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (r_inflight),
      .i_pop  (w_pop),
      .i_din  (w_din),
      .o_head (w_head),
      .o_occ  (w_occ)
   );

   assign bus.raddr     = r_addr;
   assign bus.ren       = w_ren;
   assign bus.pix_valid = (w_occ != 2'd0);
   assign bus.pix_data  = w_head.data;
   assign bus.pix_x     = w_head.x;
   assign bus.pix_y     = w_head.y;
   assign bus.pix_last  = w_head.last;

`ifdef MFE_RD_CHECKSUM_EN
   logic [15:0] r_sum;
   always_ff @(posedge clk or posedge reset)
      if (reset) r_sum <= '0;
      else if (r_state == RD_IDLE && i_start) r_sum <= '0;
      else if (w_pop) r_sum <= r_sum + 16'(bus.pix_data);
   assign o_checksum = r_sum;
`endif
endmodule
